// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the execute-side branch resolve unit.
package branch_resolve_unit_pkg;

  localparam int BRU_OPERAND_WIDTH = 32;
  localparam int BRU_HIST_WIDTH    = 10;

  localparam logic [BRU_OPERAND_WIDTH-1:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    BRANCH_MODE_SIMPLE      = 2'd0,
    BRANCH_MODE_GSHARE      = 2'd1,
    BRANCH_MODE_SAT_COUNTER = 2'd2
  } branch_mode_e;

  typedef struct packed {
    logic [BRU_OPERAND_WIDTH-1:0] pc;
    logic [BRU_OPERAND_WIDTH-1:0] target;
    logic                         taken;
    logic [BRU_HIST_WIDTH-1:0]    hist;
  } branch_entry_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute/predictor-facing signal bundle of the branch resolve unit.
interface branch_resolve_unit_if #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int HIST_WIDTH           = 10,
  parameter int CNT_WIDTH            = 32
);
  logic                            pred_valid_i;
  logic                            pred_ready_o;
  logic                            pred_taken_i;
  logic [OPTION_OPERAND_WIDTH-1:0] pred_pc_i;
  logic [OPTION_OPERAND_WIDTH-1:0] pred_target_i;
  logic [HIST_WIDTH-1:0]           pred_hist_i;
  logic                            exec_valid_i;
  logic                            flag_i;
  logic [OPTION_OPERAND_WIDTH-1:0] exec_target_i;
  logic                            pipeline_flush_i;
  logic                            branch_mispredict_o;
  logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o;
  logic                            update_valid_o;
  logic [OPTION_OPERAND_WIDTH-1:0] update_pc_o;
  logic                            update_taken_o;
  logic [HIST_WIDTH-1:0]           update_hist_o;
  logic                            resolve_err_o;
  logic [CNT_WIDTH-1:0]            branch_cnt_o;
  logic [CNT_WIDTH-1:0]            mispredict_cnt_o;

  modport master (
    output pred_valid_i, pred_taken_i, pred_pc_i, pred_target_i, pred_hist_i,
    output exec_valid_i, flag_i, exec_target_i, pipeline_flush_i,
    input  pred_ready_o, branch_mispredict_o, redirect_pc_o,
    input  update_valid_o, update_pc_o, update_taken_o, update_hist_o,
    input  resolve_err_o, branch_cnt_o, mispredict_cnt_o
  );

  modport slave (
    input  pred_valid_i, pred_taken_i, pred_pc_i, pred_target_i, pred_hist_i,
    input  exec_valid_i, flag_i, exec_target_i, pipeline_flush_i,
    output pred_ready_o, branch_mispredict_o, redirect_pc_o,
    output update_valid_o, update_pc_o, update_taken_o, update_hist_o,
    output resolve_err_o, branch_cnt_o, mispredict_cnt_o
  );
endinterface

// File: rtl/branch_resolve_unit_queue.sv
// Generic synchronous FIFO with a clear input; pointers carry one extra wrap bit.
module branch_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

  logic [IDX_W:0]   wr_ptr_r;
  logic [IDX_W:0]   rd_ptr_r;
  logic [IDX_W:0]   wr_ptr_nxt_s;
  logic [IDX_W:0]   rd_ptr_nxt_s;
  logic             do_push_s;
  logic             do_pop_s;
  logic [WIDTH-1:0] mem_r [DEPTH];

  assign full_o  = (wr_ptr_r[IDX_W] != rd_ptr_r[IDX_W]) &&
                   (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]);
  assign empty_o = (wr_ptr_r == rd_ptr_r);
  assign rdata_o = mem_r[rd_ptr_r[IDX_W-1:0]];

  // Pointer update; a same-cycle pop frees the slot so a full queue still accepts a push.
  always_comb begin
    do_pop_s     = pop_i && !empty_o;
    do_push_s    = push_i && (!full_o || do_pop_s) && !clr_i;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (clr_i) begin
      wr_ptr_nxt_s = '0;
      rd_ptr_nxt_s = '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
    end
  end

  // Entry storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[IDX_W-1:0]] <= wdata_i;
    end
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves queued branch predictions against execute outcomes: redirect, training update, counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = BRU_OPERAND_WIDTH,
  parameter int QUEUE_DEPTH          = 4,
  parameter int HIST_WIDTH           = BRU_HIST_WIDTH,
  parameter int CNT_WIDTH            = 32
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_unit_if.slave bus
);
  localparam int ENTRY_W = $bits(branch_entry_t);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [OPTION_OPERAND_WIDTH-1:0] PC_STEP = OPTION_OPERAND_WIDTH'(PC_INCR);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  branch_entry_t               wr_entry_s;
  branch_entry_t               head_s;
  logic [ENTRY_W-1:0]          head_bits_s;
  logic                        full_s;
  logic                        empty_s;
  logic                        resolve_s;
  logic                        mispredict_s;
  logic                        clr_s;

  logic                            upd_valid_r, upd_valid_nxt_s;
  logic [OPTION_OPERAND_WIDTH-1:0] upd_pc_r, upd_pc_nxt_s;
  logic                            upd_taken_r, upd_taken_nxt_s;
  logic [HIST_WIDTH-1:0]           upd_hist_r, upd_hist_nxt_s;
  logic                            mispredict_r, mispredict_nxt_s;
  logic [OPTION_OPERAND_WIDTH-1:0] redirect_r, redirect_nxt_s;
  logic                            err_r, err_nxt_s;
  logic [CNT_WIDTH-1:0]            bcnt_r, bcnt_nxt_s;
  logic [CNT_WIDTH-1:0]            mcnt_r, mcnt_nxt_s;

  // Entry packing and resolve decision; flush overrides any same-cycle resolve.
  always_comb begin
    wr_entry_s.pc     = bus.pred_pc_i;
    wr_entry_s.target = bus.pred_target_i;
    wr_entry_s.taken  = bus.pred_taken_i;
    wr_entry_s.hist   = bus.pred_hist_i;
    head_s            = branch_entry_t'(head_bits_s);
    resolve_s         = bus.exec_valid_i && !empty_s && !bus.pipeline_flush_i;
    mispredict_s      = resolve_s &&
                        ((head_s.taken != bus.flag_i) ||
                         (head_s.taken && (bus.exec_target_i != head_s.target)));
    clr_s             = bus.pipeline_flush_i || mispredict_s;
  end

  branch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr_s),
    .push_i  (bus.pred_valid_i),
    .pop_i   (resolve_s),
    .wdata_i (wr_entry_s),
    .rdata_o (head_bits_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Next values of the output stage, error flag and counters.
  always_comb begin
    upd_valid_nxt_s  = 1'b0;
    upd_pc_nxt_s     = upd_pc_r;
    upd_taken_nxt_s  = upd_taken_r;
    upd_hist_nxt_s   = upd_hist_r;
    mispredict_nxt_s = 1'b0;
    redirect_nxt_s   = redirect_r;
    bcnt_nxt_s       = bcnt_r;
    mcnt_nxt_s       = mcnt_r;
    err_nxt_s        = err_r;
    if (resolve_s) begin
      upd_valid_nxt_s = 1'b1;
      upd_pc_nxt_s    = head_s.pc;
      upd_taken_nxt_s = bus.flag_i;
      upd_hist_nxt_s  = head_s.hist;
      bcnt_nxt_s      = sat_inc(bcnt_r);
      if (mispredict_s) begin
        mispredict_nxt_s = 1'b1;
        redirect_nxt_s   = bus.flag_i ? bus.exec_target_i : head_s.pc + PC_STEP;
        mcnt_nxt_s       = sat_inc(mcnt_r);
      end else begin
        mispredict_nxt_s = 1'b0;
      end
    end else begin
      upd_valid_nxt_s = 1'b0;
    end
    if (bus.exec_valid_i && empty_s && !bus.pipeline_flush_i) begin
      err_nxt_s = 1'b1;
    end else begin
      err_nxt_s = err_r;
    end
  end

  // Registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_valid_r  <= 1'b0;
      upd_pc_r     <= '0;
      upd_taken_r  <= 1'b0;
      upd_hist_r   <= '0;
      mispredict_r <= 1'b0;
      redirect_r   <= '0;
      err_r        <= 1'b0;
      bcnt_r       <= '0;
      mcnt_r       <= '0;
    end else begin
      upd_valid_r  <= upd_valid_nxt_s;
      upd_pc_r     <= upd_pc_nxt_s;
      upd_taken_r  <= upd_taken_nxt_s;
      upd_hist_r   <= upd_hist_nxt_s;
      mispredict_r <= mispredict_nxt_s;
      redirect_r   <= redirect_nxt_s;
      err_r        <= err_nxt_s;
      bcnt_r       <= bcnt_nxt_s;
      mcnt_r       <= mcnt_nxt_s;
    end
  end

  assign bus.pred_ready_o        = !full_s;
  assign bus.update_valid_o      = upd_valid_r;
  assign bus.update_pc_o         = upd_pc_r;
  assign bus.update_taken_o      = upd_taken_r;
  assign bus.update_hist_o       = upd_hist_r;
  assign bus.branch_mispredict_o = mispredict_r;
  assign bus.redirect_pc_o       = redirect_r;
  assign bus.resolve_err_o       = err_r;
  assign bus.branch_cnt_o        = bcnt_r;
  assign bus.mispredict_cnt_o    = mcnt_r;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed, table-driven bench for branch_resolve_unit; counters narrowed to 3 bits to reach saturation.
module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  int   eb = 0;
  int   em = 0;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.OPTION_OPERAND_WIDTH(32), .HIST_WIDTH(10), .CNT_WIDTH(3)) bus ();

  branch_resolve_unit #(.OPTION_OPERAND_WIDTH(32), .QUEUE_DEPTH(4), .HIST_WIDTH(10), .CNT_WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic push; logic pt; logic [31:0] ppc; logic [31:0] ptgt; logic [9:0] ph;
    logic ex; logic fl; logic [31:0] et; logic flush;
    logic e_uv; logic [31:0] e_upc; logic e_ut; logic [9:0] e_uh;
    logic e_mp; logic [31:0] e_redir; logic e_ready; logic e_err; int e_b; int e_m;
  } vec_t;

  vec_t vecs [13];

  function automatic int sat(input int v);
    return (v > 7) ? 7 : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic uv, input logic [31:0] upc, input logic ut,
                         input logic [9:0] uh, input logic mp, input logic [31:0] redir,
                         input logic ready, input logic err, input int b, input int m);
    chk({tag, ".update_valid"}, 32'(bus.update_valid_o), 32'(uv));
    chk({tag, ".mispredict"}, 32'(bus.branch_mispredict_o), 32'(mp));
    chk({tag, ".pred_ready"}, 32'(bus.pred_ready_o), 32'(ready));
    chk({tag, ".resolve_err"}, 32'(bus.resolve_err_o), 32'(err));
    chk({tag, ".branch_cnt"}, 32'(bus.branch_cnt_o), 32'(b));
    chk({tag, ".mispredict_cnt"}, 32'(bus.mispredict_cnt_o), 32'(m));
    if (uv) begin
      chk({tag, ".update_pc"}, bus.update_pc_o, upc);
      chk({tag, ".update_taken"}, 32'(bus.update_taken_o), 32'(ut));
      chk({tag, ".update_hist"}, 32'(bus.update_hist_o), 32'(uh));
    end
    if (mp) chk({tag, ".redirect_pc"}, bus.redirect_pc_o, redir);
  endtask

  task automatic drive(input logic push, input logic pt, input logic [31:0] ppc, input logic [31:0] ptgt,
                       input logic [9:0] ph, input logic ex, input logic fl, input logic [31:0] et,
                       input logic flush);
    bus.pred_valid_i     = push;
    bus.pred_taken_i     = pt;
    bus.pred_pc_i        = ppc;
    bus.pred_target_i    = ptgt;
    bus.pred_hist_i      = ph;
    bus.exec_valid_i     = ex;
    bus.flag_i           = fl;
    bus.exec_target_i    = et;
    bus.pipeline_flush_i = flush;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // push, pt, ppc, ptgt, ph, ex, fl, et, flush, uv, upc, ut, uh, mp, redir, ready, err, b, m
    vecs[0]  = '{1'b1, 1'b1, 32'h100, 32'h140, 10'h3A5, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 10'h0, 1'b0, 32'h0, 1'b1, 1'b0, 0, 0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0, 32'h0, 10'h0, 1'b1, 1'b1, 32'h140, 1'b0, 1'b1, 32'h100, 1'b1, 10'h3A5, 1'b0, 32'h0, 1'b1, 1'b0, 1, 0};
    vecs[2]  = '{1'b1, 1'b0, 32'h200, 32'h0, 10'h011, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 10'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1, 0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0, 32'h0, 10'h0, 1'b1, 1'b1, 32'h260, 1'b0, 1'b1, 32'h200, 1'b1, 10'h011, 1'b1, 32'h260, 1'b1, 1'b0, 2, 1};
    vecs[4]  = '{1'b1, 1'b1, 32'h300, 32'h340, 10'h0AA, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 10'h0, 1'b0, 32'h0, 1'b1, 1'b0, 2, 1};
    vecs[5]  = '{1'b1, 1'b0, 32'h310, 32'h0, 10'h0AB, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 10'h0, 1'b0, 32'h0, 1'b1, 1'b0, 2, 1};
    vecs[6]  = '{1'b1, 1'b0, 32'h320, 32'h0, 10'h0AC, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 10'h0, 1'b0, 32'h0, 1'b1, 1'b0, 2, 1};
    vecs[7]  = '{1'b0, 1'b0, 32'h0, 32'h0, 10'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b0, 10'h0AA, 1'b1, 32'h304, 1'b1, 1'b0, 3, 2};
    vecs[8]  = '{1'b0, 1'b0, 32'h0, 32'h0, 10'h0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 10'h0, 1'b0, 32'h0, 1'b1, 1'b1, 3, 2};
    vecs[9]  = '{1'b1, 1'b1, 32'h400, 32'h440, 10'h1FF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 10'h0, 1'b0, 32'h0, 1'b1, 1'b1, 3, 2};
    vecs[10] = '{1'b0, 1'b0, 32'h0, 32'h0, 10'h0, 1'b1, 1'b1, 32'h480, 1'b0, 1'b1, 32'h400, 1'b1, 10'h1FF, 1'b1, 32'h480, 1'b1, 1'b1, 4, 3};
    vecs[11] = '{1'b1, 1'b0, 32'h500, 32'h0, 10'h000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 10'h0, 1'b0, 32'h0, 1'b1, 1'b1, 4, 3};
    vecs[12] = '{1'b0, 1'b0, 32'h0, 32'h0, 10'h0, 1'b1, 1'b0, 32'h999, 1'b0, 1'b1, 32'h500, 1'b0, 10'h000, 1'b0, 32'h0, 1'b1, 1'b1, 5, 3};

    drive(1'b0, 1'b0, 32'h0, 32'h0, 10'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_all("reset", 1'b0, 32'h0, 1'b0, 10'h0, 1'b0, 32'h0, 1'b1, 1'b0, 0, 0);
    chk("reset.update_pc", bus.update_pc_o, 32'h0);
    chk("reset.redirect_pc", bus.redirect_pc_o, 32'h0);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].push, vecs[i].pt, vecs[i].ppc, vecs[i].ptgt, vecs[i].ph,
            vecs[i].ex, vecs[i].fl, vecs[i].et, vecs[i].flush);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_uv, vecs[i].e_upc, vecs[i].e_ut, vecs[i].e_uh,
              vecs[i].e_mp, vecs[i].e_redir, vecs[i].e_ready, vecs[i].e_err, vecs[i].e_b, vecs[i].e_m);
    end
    eb = 5;
    em = 3;

    // Fill to capacity, then push and resolve in the same cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h600 + 32'(i) * 32'h10, 32'h0, 10'(i), 1'b0, 1'b0, 32'h0, 1'b0);
      step();
      chk_all($sformatf("fill%0d", i), 1'b0, 32'h0, 1'b0, 10'h0, 1'b0, 32'h0, (i < 3), 1'b1, eb, em);
    end
    drive(1'b1, 1'b0, 32'h640, 32'h0, 10'd4, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    eb = sat(eb + 1);
    chk_all("full_push_pop", 1'b1, 32'h600, 1'b0, 10'd0, 1'b0, 32'h0, 1'b0, 1'b1, eb, em);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 10'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      step();
      eb = sat(eb + 1);
      chk_all($sformatf("drain%0d", i), 1'b1, 32'h610 + 32'(i) * 32'h10, 1'b0, 10'(i + 1),
              1'b0, 32'h0, 1'b1, 1'b1, eb, em);
    end

    // Flush with a same-cycle resolve and push: nothing survives.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h700 + 32'(i) * 32'h10, 32'h740, 10'd7, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
    end
    drive(1'b1, 1'b0, 32'h730, 32'h0, 10'd3, 1'b1, 1'b0, 32'h0, 1'b1);
    step();
    chk_all("flush", 1'b0, 32'h0, 1'b0, 10'h0, 1'b0, 32'h0, 1'b1, 1'b1, eb, em);
    drive(1'b1, 1'b0, 32'h750, 32'h0, 10'd5, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 10'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    eb = sat(eb + 1);
    chk_all("post_flush", 1'b1, 32'h750, 1'b0, 10'd5, 1'b0, 32'h0, 1'b1, 1'b1, eb, em);

    // Mispredict stream up to and past counter saturation.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'h800 + 32'(i) * 32'h10, 32'h0, 10'(i), 1'b0, 1'b0, 32'h0, 1'b0);
      step();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 10'h0, 1'b1, 1'b1, 32'h880, 1'b0);
      step();
      eb = sat(eb + 1);
      em = sat(em + 1);
      chk_all($sformatf("msat%0d", i), 1'b1, 32'h800 + 32'(i) * 32'h10, 1'b1, 10'(i),
              1'b1, 32'h880, 1'b1, 1'b1, eb, em);
    end

    // Push in the mispredict cycle is dropped.
    drive(1'b1, 1'b1, 32'h900, 32'h940, 10'd9, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b1, 1'b0, 32'h910, 32'h0, 10'd1, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    eb = sat(eb + 1);
    em = sat(em + 1);
    chk_all("mp_drop", 1'b1, 32'h900, 1'b0, 10'd9, 1'b1, 32'h904, 1'b1, 1'b1, eb, em);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 10'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    chk_all("mp_drop_empty", 1'b0, 32'h0, 1'b0, 10'h0, 1'b0, 32'h0, 1'b1, 1'b1, eb, em);

    // Reset in the middle of traffic.
    drive(1'b1, 1'b0, 32'hA00, 32'h0, 10'd1, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b1, 1'b0, 32'hA10, 32'h0, 10'd2, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'hA20, 32'h0, 10'd3, 1'b1, 1'b1, 32'hA80, 1'b0);
    step();
    rst = 1'b0;
    chk_all("mid_reset", 1'b0, 32'h0, 1'b0, 10'h0, 1'b0, 32'h0, 1'b1, 1'b0, 0, 0);
    chk("mid_reset.update_pc", bus.update_pc_o, 32'h0);
    chk("mid_reset.update_hist", 32'(bus.update_hist_o), 32'h0);
    chk("mid_reset.redirect_pc", bus.redirect_pc_o, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 10'h0, 1'b1, 1'b1, 32'h0, 1'b0);
    step();
    chk_all("after_reset_empty", 1'b0, 32'h0, 1'b0, 10'h0, 1'b0, 32'h0, 1'b1, 1'b1, 0, 0);

    drive(1'b0, 1'b0, 32'h0, 32'h0, 10'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
